// File: rtl/uv_quantize_if.sv
// Chroma quantizer request/response bundle: latched-on-start inputs plus
// registered level/dequant outputs and completion pulse.
interface uv_quantize_if #(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8
);
    localparam int BUS_W = BIT_WIDTH * 16 * BLOCK_SIZE;

    logic                  start;
    logic [BUS_W-1:0]      coeffs;
    logic [7:0]            q_dc;
    logic [7:0]            q_ac;
    logic [15:0]           iq_dc;
    logic [15:0]           iq_ac;
    logic [31:0]           bias_dc;
    logic [31:0]           bias_ac;
    logic [16:0]           zthresh_dc;
    logic [16:0]           zthresh_ac;
    logic [BUS_W-1:0]      levels;
    logic [BUS_W-1:0]      dq_coeffs;
    logic [BLOCK_SIZE-1:0] nz;
    logic                  done;

    modport master (
        output start, coeffs, q_dc, q_ac, iq_dc, iq_ac,
               bias_dc, bias_ac, zthresh_dc, zthresh_ac,
        input  levels, dq_coeffs, nz, done
    );

    modport slave (
        input  start, coeffs, q_dc, q_ac, iq_dc, iq_ac,
               bias_dc, bias_ac, zthresh_dc, zthresh_ac,
        output levels, dq_coeffs, nz, done
    );
endinterface

// File: rtl/uv_quantize.sv
// VP8 chroma (U/V) quantizer: one 4x4 block of 16 coefficients per cycle,
// producing levels, dequantized coefficients and a per-block non-zero mask.
module uv_quantize #(
    parameter int BIT_WIDTH  = 16,
    parameter int BLOCK_SIZE = 8,
    parameter int QFIX       = 17,
    parameter int MAX_LEVEL  = 2047
) (
    input  logic         clk,
    input  logic         rst_n,
    uv_quantize_if.slave bus
);
    localparam int LANES  = 16;
    localparam int BLK_W  = BIT_WIDTH * LANES;
    localparam int BUS_W  = BLK_W * BLOCK_SIZE;
    localparam int CNT_W  = $clog2(BLOCK_SIZE);
    localparam int PROD_W = 34;
    localparam int DQ_W   = 20;

    localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [PROD_W-1:0]        LVL_MAX  = PROD_W'(MAX_LEVEL);
    localparam logic signed [DQ_W-1:0]   DQ_MAX   = DQ_W'((1 << (BIT_WIDTH - 1)) - 1);
    localparam logic signed [DQ_W-1:0]   DQ_MIN   = DQ_W'(-(1 << (BIT_WIDTH - 1)));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   load_s;
    logic   run_s;
    logic   fin_s;

    logic [CNT_W-1:0]      cnt_r;
    logic [BUS_W-1:0]      coeffs_r;
    logic [7:0]            q_dc_r;
    logic [7:0]            q_ac_r;
    logic [15:0]           iq_dc_r;
    logic [15:0]           iq_ac_r;
    logic [31:0]           bias_dc_r;
    logic [31:0]           bias_ac_r;
    logic [16:0]           zthresh_dc_r;
    logic [16:0]           zthresh_ac_r;
    logic [BUS_W-1:0]      levels_r;
    logic [BUS_W-1:0]      dq_coeffs_r;
    logic [BLOCK_SIZE-1:0] nz_r;
    logic                  done_r;

    logic [BLK_W-1:0]       blk_coeffs_s;
    logic [BLK_W-1:0]       blk_levels_s;
    logic [BLK_W-1:0]       blk_dq_s;
    logic                   blk_nz_s;
    logic [2*BIT_WIDTH-1:0] qres_s;

    // Quantize one coefficient; returns {level, saturated dequantized value}.
    // The magnitude is 17 bits so that -32768 maps to +32768 without wrapping.
    function automatic logic [2*BIT_WIDTH-1:0] quant_coeff(
        input logic [BIT_WIDTH-1:0] c,
        input logic [7:0]           q,
        input logic [15:0]          iq,
        input logic [31:0]          bias,
        input logic [16:0]          zth
    );
        logic                        sgn;
        logic [BIT_WIDTH:0]          mag;
        logic [PROD_W-1:0]           prod;
        logic [PROD_W-1:0]           lvl_abs;
        logic signed [BIT_WIDTH-1:0] lvl;
        logic signed [DQ_W-1:0]      lvl_w;
        logic signed [DQ_W-1:0]      q_w;
        logic signed [DQ_W-1:0]      dq;
        logic [BIT_WIDTH-1:0]        dq_sat;

        sgn  = c[BIT_WIDTH-1];
        mag  = sgn ? (~{c[BIT_WIDTH-1], c} + 1'b1) : {1'b0, c};
        prod = PROD_W'(mag) * PROD_W'(iq) + PROD_W'(bias);

        lvl_abs = (mag > zth) ? (prod >> QFIX) : {PROD_W{1'b0}};
        lvl_abs = (lvl_abs > LVL_MAX) ? LVL_MAX : lvl_abs;

        lvl   = sgn ? -$signed(lvl_abs[BIT_WIDTH-1:0]) : $signed(lvl_abs[BIT_WIDTH-1:0]);
        lvl_w = DQ_W'(lvl);
        q_w   = {{(DQ_W-8){1'b0}}, q};
        dq    = lvl_w * q_w;

        if (dq > DQ_MAX) begin
            dq_sat = DQ_MAX[BIT_WIDTH-1:0];
        end else if (dq < DQ_MIN) begin
            dq_sat = DQ_MIN[BIT_WIDTH-1:0];
        end else begin
            dq_sat = dq[BIT_WIDTH-1:0];
        end
        return {lvl, dq_sat};
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and phase strobes; start outside IDLE is deliberately ignored.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        run_s        = 1'b0;
        fin_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    state_next_s = RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                run_s = 1'b1;
                if (cnt_r == LAST_CNT) begin
                    state_next_s = FIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            FIN: begin
                fin_s        = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Quantize the latched block selected by cnt: lane 0 is DC, lanes 1..15 AC.
    always_comb begin
        blk_coeffs_s = coeffs_r[int'(cnt_r) * BLK_W +: BLK_W];
        blk_levels_s = '0;
        blk_dq_s     = '0;
        blk_nz_s     = 1'b0;
        qres_s       = '0;
        for (int j = 0; j < LANES; j++) begin
            if (j == 0) begin
                qres_s = quant_coeff(blk_coeffs_s[j*BIT_WIDTH +: BIT_WIDTH],
                                     q_dc_r, iq_dc_r, bias_dc_r, zthresh_dc_r);
            end else begin
                qres_s = quant_coeff(blk_coeffs_s[j*BIT_WIDTH +: BIT_WIDTH],
                                     q_ac_r, iq_ac_r, bias_ac_r, zthresh_ac_r);
            end
            blk_levels_s[j*BIT_WIDTH +: BIT_WIDTH] = qres_s[2*BIT_WIDTH-1:BIT_WIDTH];
            blk_dq_s[j*BIT_WIDTH +: BIT_WIDTH]     = qres_s[BIT_WIDTH-1:0];
            blk_nz_s = blk_nz_s | (|qres_s[2*BIT_WIDTH-1:BIT_WIDTH]);
        end
    end

    // Input capture, per-block result write-back and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            coeffs_r     <= '0;
            q_dc_r       <= 8'd0;
            q_ac_r       <= 8'd0;
            iq_dc_r      <= 16'd0;
            iq_ac_r      <= 16'd0;
            bias_dc_r    <= 32'd0;
            bias_ac_r    <= 32'd0;
            zthresh_dc_r <= 17'd0;
            zthresh_ac_r <= 17'd0;
            levels_r     <= '0;
            dq_coeffs_r  <= '0;
            nz_r         <= '0;
            done_r       <= 1'b0;
        end else begin
            done_r <= fin_s;
            if (load_s) begin
                cnt_r        <= '0;
                nz_r         <= '0;
                coeffs_r     <= bus.coeffs;
                q_dc_r       <= bus.q_dc;
                q_ac_r       <= bus.q_ac;
                iq_dc_r      <= bus.iq_dc;
                iq_ac_r      <= bus.iq_ac;
                bias_dc_r    <= bus.bias_dc;
                bias_ac_r    <= bus.bias_ac;
                zthresh_dc_r <= bus.zthresh_dc;
                zthresh_ac_r <= bus.zthresh_ac;
            end else if (run_s) begin
                levels_r[int'(cnt_r) * BLK_W +: BLK_W]    <= blk_levels_s;
                dq_coeffs_r[int'(cnt_r) * BLK_W +: BLK_W] <= blk_dq_s;
                nz_r[cnt_r]                               <= blk_nz_s;
                cnt_r                                     <= cnt_r + 1'b1;
            end
        end
    end

    assign bus.levels    = levels_r;
    assign bus.dq_coeffs = dq_coeffs_r;
    assign bus.nz        = nz_r;
    assign bus.done      = done_r;
endmodule

// File: tb/tb_uv_quantize.sv
// Directed self-checking bench for uv_quantize with hand-computed expectations.
module tb_uv_quantize;
    localparam int BUS_W = 16 * 16 * 8;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   lat;
    int   saw_done;
    logic [BUS_W-1:0] exp_lv;
    logic [BUS_W-1:0] exp_dq;

    uv_quantize_if #(.BIT_WIDTH(16), .BLOCK_SIZE(8)) bus ();

    uv_quantize dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BUS_W-1:0] fill(input logic [15:0] v);
        logic [BUS_W-1:0] r;
        for (int i = 0; i < 128; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        int bad;
        bad = -1;
        for (int i = 127; i >= 0; i--) if (obs[i*16 +: 16] !== exp[i*16 +: 16]) bad = i;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: block %0d coeff %0d observed %0d expected %0d", tag, bad / 16, bad % 16,
                   $signed(obs[bad*16 +: 16]), $signed(exp[bad*16 +: 16]));
        end
    endtask

    task automatic set_params(input logic [7:0] qd, input logic [7:0] qa,
                              input logic [15:0] iqd, input logic [15:0] iqa,
                              input logic [31:0] bd, input logic [31:0] ba,
                              input logic [16:0] zd, input logic [16:0] za);
        bus.q_dc = qd;        bus.q_ac = qa;
        bus.iq_dc = iqd;      bus.iq_ac = iqa;
        bus.bias_dc = bd;     bus.bias_ac = ba;
        bus.zthresh_dc = zd;  bus.zthresh_ac = za;
    endtask

    // Start high across one rising edge (E0); returns at the falling edge after E0.
    task automatic launch();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Waits for done, counting edges from E0; optionally pulses start across edge pulse_at.
    task automatic wait_done(input int pulse_at, output int l);
        l = -1;
        for (int c = 1; c <= 20; c++) begin
            bus.start = (c == pulse_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            if (bus.done === 1'b1) begin
                l = c;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.coeffs = '0;
        set_params(8'd0, 8'd0, 16'd0, 16'd0, 32'd0, 32'd0, 17'd0, 17'd0);
        repeat (3) @(negedge clk);
        chk_bus("reset_levels", bus.levels, '0);
        chk_bus("reset_dq", bus.dq_coeffs, '0);
        chk("reset_nz", 32'(bus.nz), 32'h0);
        chk("reset_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: 100*16384>>17 = 12, dq 96; inputs scrambled after acceptance
        set_params(8'd8, 8'd8, 16'd16384, 16'd16384, 32'd0, 32'd0, 17'd0, 17'd0);
        bus.coeffs = fill(16'd100);
        launch();
        bus.coeffs = fill(16'd7777);
        bus.iq_ac  = 16'd1;
        wait_done(0, lat);
        chk("t1_latency", 32'(lat), 32'd9);
        chk_bus("t1_levels", bus.levels, fill(16'd12));
        chk_bus("t1_dq", bus.dq_coeffs, fill(16'd96));
        chk("t1_nz", 32'(bus.nz), 32'hFF);
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(bus.done), 32'h0);
        repeat (3) @(negedge clk);
        chk_bus("t1_levels_hold", bus.levels, fill(16'd12));

        // T2: -100 with bias 65536 -> -13, dq -104; stray start at E4 must be ignored
        set_params(8'd8, 8'd8, 16'd16384, 16'd16384, 32'd65536, 32'd65536, 17'd0, 17'd0);
        bus.coeffs = fill(16'hFF9C);
        launch();
        bus.coeffs = fill(16'd0);
        wait_done(4, lat);
        chk("t2_latency_with_stray_start", 32'(lat), 32'd9);
        chk_bus("t2_levels", bus.levels, fill(16'hFFF3));
        chk_bus("t2_dq", bus.dq_coeffs, fill(16'hFF98));
        chk("t2_nz", 32'(bus.nz), 32'hFF);

        // T3: started during the done cycle; block 3 at zero threshold -> zero
        exp_lv = fill(16'd12);
        exp_dq = fill(16'd96);
        bus.coeffs = fill(16'd100);
        for (int j = 0; j < 16; j++) begin
            bus.coeffs[(3*16 + j)*16 +: 16] = 16'd20;
            exp_lv[(3*16 + j)*16 +: 16] = 16'd0;
            exp_dq[(3*16 + j)*16 +: 16] = 16'd0;
        end
        set_params(8'd8, 8'd8, 16'd16384, 16'd16384, 32'd0, 32'd0, 17'd20, 17'd20);
        launch();
        chk("t2_done_cleared", 32'(bus.done), 32'h0);
        wait_done(0, lat);
        chk("t3_back_to_back_latency", 32'(lat), 32'd9);
        chk_bus("t3_levels", bus.levels, exp_lv);
        chk_bus("t3_dq", bus.dq_coeffs, exp_dq);
        chk("t3_nz", 32'(bus.nz), 32'hF7);
        @(negedge clk);

        // T4: clamp/saturation and DC/AC parameter split
        bus.coeffs = '0;
        bus.coeffs[0*16 +: 16]  = 16'h8000;        // -32768, DC
        bus.coeffs[1*16 +: 16]  = 16'h7FFF;        // 32767, AC
        bus.coeffs[32*16 +: 16] = 16'd300;         // block 2 DC
        bus.coeffs[47*16 +: 16] = 16'hFC18;        // block 2 coeff 15 = -1000
        set_params(8'd127, 8'd16, 16'd65535, 16'd65535, 32'd0, 32'd0, 17'd0, 17'd0);
        exp_lv = '0;
        exp_dq = '0;
        exp_lv[0*16 +: 16]  = 16'hF801;            // -2047
        exp_dq[0*16 +: 16]  = 16'h8000;            // -32768
        exp_lv[1*16 +: 16]  = 16'd2047;
        exp_dq[1*16 +: 16]  = 16'd32752;
        exp_lv[32*16 +: 16] = 16'd149;
        exp_dq[32*16 +: 16] = 16'd18923;           // 149*127
        exp_lv[47*16 +: 16] = 16'hFE0D;            // -499
        exp_dq[47*16 +: 16] = 16'hE0D0;            // -7984
        launch();
        wait_done(0, lat);
        chk("t4_latency", 32'(lat), 32'd9);
        chk_bus("t4_levels", bus.levels, exp_lv);
        chk_bus("t4_dq", bus.dq_coeffs, exp_dq);
        chk("t4_nz", 32'(bus.nz), 32'h05);
        @(negedge clk);

        // T5: reset mid-RUN clears outputs immediately and suppresses done
        set_params(8'd8, 8'd8, 16'd16384, 16'd16384, 32'd0, 32'd0, 17'd0, 17'd0);
        bus.coeffs = fill(16'd100);
        launch();
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_bus("midrun_reset_levels", bus.levels, '0);
        chk_bus("midrun_reset_dq", bus.dq_coeffs, '0);
        chk("midrun_reset_nz", 32'(bus.nz), 32'h0);
        chk("midrun_reset_done", 32'(bus.done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) saw_done = 1;
        end
        chk("no_done_after_reset", 32'(saw_done), 32'd0);
        chk("nz_after_reset", 32'(bus.nz), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
